// File: rtl/lock_entry_controller.sv
// lock_entry_controller: sequences keypad code bits into the serial-code lock
// core, then judges the attempt from the core's unlocked flag. It also handles
// the entry timeout, consecutive-failure counting, the timed lockout with
// alarm, and relocking the door.
//
// Build option: define LOCK_AUTO_RELOCK_EN to make OPEN also time out after
// OPEN_CYCLES. Without it, OPEN is held until a manual relock.
//
// Handshake: inputs are level-sampled on the rising edge. A bit is taken when
// key_valid=1 in IDLE/ENTRY and is presented to the core as a one-cycle
// core_step with core_x on the next cycle. There is no backpressure. Bits
// offered in other states are dropped silently.
//
// dbg_state exposes the FSM state (IDLE=0 ENTRY=1 SETTLE=2 CHECK=3 OPEN=4
// LOCKOUT=5) so that checkers can bind to it.
module lock_entry_controller #(
    parameter int MAX_BITS       = 16,
    parameter int ENTRY_TIMEOUT  = 1000,
    parameter int OPEN_CYCLES    = 5000,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 10000,
    parameter int TW             = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic       key_bit,
    input  logic       enter,
    input  logic       relock,
    input  logic       core_unlocked,
    output logic       core_x,
    output logic       core_step,
    output logic       core_clr,
    output logic       unlock,
    output logic       alarm,
    output logic [1:0] fail_cnt,
    output logic [2:0] dbg_state
);

    localparam int              BCW        = $clog2(MAX_BITS + 1);
    localparam logic [BCW-1:0]  BITS_MAX   = BCW'(MAX_BITS);
    localparam logic [TW-1:0]   ENTRY_LAST = TW'(ENTRY_TIMEOUT - 1);
    localparam logic [TW-1:0]   LOCK_LAST  = TW'(LOCKOUT_CYCLES - 1);
`ifdef LOCK_AUTO_RELOCK_EN
    localparam logic [TW-1:0]   OPEN_LAST  = TW'(OPEN_CYCLES - 1);
`endif
    localparam logic [1:0]      FAILS_MAX  = 2'(MAX_FAILS);
    localparam logic [1:0]      FAILS_LAST = 2'(MAX_FAILS - 1);

    // The timer and the 2-bit fail counter only work for parameters in range.
    if (MAX_FAILS < 1 || MAX_FAILS > 3 || MAX_BITS < 1 ||
        ENTRY_TIMEOUT < 1 || ENTRY_TIMEOUT >= (1 << TW) ||
        OPEN_CYCLES < 1 || OPEN_CYCLES >= (1 << TW) ||
        LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES >= (1 << TW)) begin : g_param_check
        $error("lock_entry_controller: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_SETTLE  = 3'd2,
        S_CHECK   = 3'd3,
        S_OPEN    = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic           force_fail_q, force_fail_d;
    logic [1:0]     fail_cnt_q, fail_cnt_d;
    logic           core_x_q, core_x_d;
    logic           core_step_q, core_step_d;
    logic           core_clr_q, core_clr_d;
    logic           timer_reload;

    // State, counters and core-facing pulses. The core shares this reset, so
    // reset issues no core_clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            bit_cnt_q    <= '0;
            force_fail_q <= 1'b0;
            fail_cnt_q   <= 2'd0;
            core_x_q     <= 1'b0;
            core_step_q  <= 1'b0;
            core_clr_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_cnt_q    <= bit_cnt_d;
            force_fail_q <= force_fail_d;
            fail_cnt_q   <= fail_cnt_d;
            core_x_q     <= core_x_d;
            core_step_q  <= core_step_d;
            core_clr_q   <= core_clr_d;
        end
    end

    // Next-state, bit gating, attempt judgement and timer control.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        force_fail_d = force_fail_q;
        fail_cnt_d   = fail_cnt_q;
        core_x_d     = 1'b0;
        core_step_d  = 1'b0;
        timer_reload = 1'b0;
        core_clr_d   = 1'b0;
        timer_d      = '0;

        case (state_q)
            S_IDLE: begin
                if (key_valid) begin
                    core_step_d = 1'b1;
                    core_x_d    = key_bit;
                    bit_cnt_d   = BCW'(1);
                    state_d     = enter ? S_SETTLE : S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (key_valid) begin
                    timer_reload = 1'b1;
                    if (bit_cnt_q == BITS_MAX) begin
                        // An over-long code can never be correct.
                        force_fail_d = 1'b1;
                    end else begin
                        core_step_d = 1'b1;
                        core_x_d    = key_bit;
                        bit_cnt_d   = bit_cnt_q + BCW'(1);
                    end
                end
                if (enter) begin
                    state_d = S_SETTLE;
                end else if (!key_valid && timer_q == ENTRY_LAST) begin
                    force_fail_d = 1'b1;
                    state_d      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (core_unlocked && !force_fail_q) begin
                    fail_cnt_d = 2'd0;
                    state_d    = S_OPEN;
                end else if (fail_cnt_q == FAILS_LAST) begin
                    fail_cnt_d = FAILS_MAX;
                    state_d    = S_LOCKOUT;
                end else begin
                    fail_cnt_d = fail_cnt_q + 2'd1;
                    state_d    = S_IDLE;
                end
            end
            S_OPEN: begin
                if (relock) begin
                    state_d = S_IDLE;
                end
`ifdef LOCK_AUTO_RELOCK_EN
                else if (timer_q == OPEN_LAST) begin
                    state_d = S_IDLE;
                end
`endif
            end
            S_LOCKOUT: begin
                if (timer_q == LOCK_LAST) begin
                    fail_cnt_d = 2'd0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Any return to IDLE restarts the core and the attempt bookkeeping.
        if (state_d == S_IDLE && state_q != S_IDLE) begin
            core_clr_d   = 1'b1;
            bit_cnt_d    = '0;
            force_fail_d = 1'b0;
        end

        if (state_d != state_q || timer_reload) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    assign core_x    = core_x_q;
    assign core_step = core_step_q;
    assign core_clr  = core_clr_q;
    assign unlock    = (state_q == S_OPEN);
    assign alarm     = (state_q == S_LOCKOUT);
    assign fail_cnt  = fail_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lock_entry_controller.sv
// Directed bench for lock_entry_controller: one task per scenario, with a
// scoreboard queue of code bits expected on core_x at each core_step.
module tb_lock_entry_controller;

    localparam int MAX_BITS       = 16;
    localparam int ENTRY_TIMEOUT  = 1000;
    localparam int OPEN_CYCLES    = 5000;
    localparam int MAX_FAILS      = 3;
    localparam int LOCKOUT_CYCLES = 10000;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ENTRY   = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_CHECK   = 3'd3;
    localparam logic [2:0] ST_LOCKOUT = 3'd5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic       key_bit = 1'b0;
    logic       enter = 1'b0;
    logic       relock = 1'b0;
    logic       core_unlocked = 1'b0;
    logic       core_x, core_step, core_clr, unlock, alarm;
    logic [1:0] fail_cnt;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;
    int step_cnt = 0;
    logic [0:0] exp_q[$];
    logic [0:0] mon_exp;

    lock_entry_controller #(
        .MAX_BITS(MAX_BITS), .ENTRY_TIMEOUT(ENTRY_TIMEOUT), .OPEN_CYCLES(OPEN_CYCLES),
        .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .TW(16)
    ) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_bit(key_bit),
        .enter(enter), .relock(relock), .core_unlocked(core_unlocked),
        .core_x(core_x), .core_step(core_step), .core_clr(core_clr),
        .unlock(unlock), .alarm(alarm), .fail_cnt(fail_cnt), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1);
    end

    // scoreboard: every core_step must match the oldest expected bit
    always @(negedge clk) begin
        if (reset && core_step) begin
            checks++;
            step_cnt++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_step: core_step=1 core_x=%b, required no step", core_x);
            end else begin
                mon_exp = exp_q.pop_front();
                if (core_x !== mon_exp[0]) begin
                    errors++;
                    $display("FAIL core_x: got %b, required %b", core_x, mon_exp[0]);
                end
            end
        end
    end

    // driver tasks (entered and left just after a falling edge)
    task automatic send_bit(input logic b, input bit fwd);
        key_valid = 1'b1;
        key_bit   = b;
        if (fwd) exp_q.push_back(b);
        @(negedge clk);
        key_valid = 1'b0;
        key_bit   = 1'b0;
    endtask

    task automatic press_enter();
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wait_cycles(3);
        checks++;
        if ({unlock, alarm, core_step, core_clr, core_x, fail_cnt, dbg_state} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: u=%b a=%b st=%b clr=%b x=%b fc=%0d s=%0d, required all 0",
                     unlock, alarm, core_step, core_clr, core_x, fail_cnt, dbg_state);
        end
        reset = 1'b1;
        wait_cycles(2);
        checks++;
        if (dbg_state !== ST_IDLE || core_clr !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: state=%0d clr=%b, required 0 0", dbg_state, core_clr);
        end
    endtask

    task automatic test_correct_code();
        int n;
        core_unlocked = 1'b1;
        step_cnt = 0;
        send_bit(1'b1, 1'b1);
        checks++;
        if (dbg_state !== ST_ENTRY) begin
            errors++;
            $display("FAIL entry_state: state=%0d, required %0d", dbg_state, ST_ENTRY);
        end
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        press_enter();
        checks++;
        if (dbg_state !== ST_SETTLE) begin
            errors++;
            $display("FAIL settle_state: state=%0d, required %0d", dbg_state, ST_SETTLE);
        end
        @(negedge clk);
        checks++;
        if (dbg_state !== ST_CHECK || unlock !== 1'b0) begin
            errors++;
            $display("FAIL check_state: state=%0d unlock=%b, required %0d 0", dbg_state, unlock, ST_CHECK);
        end
        @(negedge clk);
        checks++;
        if (unlock !== 1'b1 || fail_cnt !== 2'd0) begin
            errors++;
            $display("FAIL open_unlock: unlock=%b fail_cnt=%0d, required 1 0", unlock, fail_cnt);
        end
        checks++;
        if (step_cnt != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL code_steps: steps=%0d pending=%0d, required 4 0", step_cnt, exp_q.size());
        end
`ifdef LOCK_AUTO_RELOCK_EN
        n = 0;
        while (unlock === 1'b1 && n < OPEN_CYCLES + 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != OPEN_CYCLES) begin
            errors++;
            $display("FAIL auto_relock_len: unlock high %0d cycles, required %0d", n, OPEN_CYCLES);
        end
        checks++;
        if (core_clr !== 1'b1) begin
            errors++;
            $display("FAIL auto_relock_clr: core_clr=%b, required 1", core_clr);
        end
`else
        n = 0;
        wait_cycles(100);
        checks++;
        if (unlock !== 1'b1) begin
            errors++;
            $display("FAIL open_hold: unlock=%b after 100 cycles, required 1", unlock);
        end
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
        checks++;
        if (unlock !== 1'b0 || core_clr !== 1'b1) begin
            errors++;
            $display("FAIL manual_relock: unlock=%b clr=%b, required 0 1", unlock, core_clr);
        end
`endif
        @(negedge clk);
        checks++;
        if (core_clr !== 1'b0) begin
            errors++;
            $display("FAIL clr_single: core_clr=%b one cycle later, required 0", core_clr);
        end
    endtask

    task automatic test_wrong_code();
        int n;
        core_unlocked = 1'b0;
        for (int a = 1; a <= MAX_FAILS; a++) begin
            send_bit(a[0], 1'b1);
            send_bit(1'b0, 1'b1);
            press_enter();
            wait_cycles(2);
            if (a < MAX_FAILS) begin
                checks++;
                if (fail_cnt !== 2'(a) || core_clr !== 1'b1 || alarm !== 1'b0) begin
                    errors++;
                    $display("FAIL wrong_attempt: a=%0d fc=%0d clr=%b alarm=%b, required %0d 1 0",
                             a, fail_cnt, core_clr, alarm, a);
                end
            end else begin
                checks++;
                if (alarm !== 1'b1 || fail_cnt !== 2'd3 || dbg_state !== ST_LOCKOUT || core_clr !== 1'b0) begin
                    errors++;
                    $display("FAIL lockout_entry: alarm=%b fc=%0d state=%0d clr=%b, required 1 3 5 0",
                             alarm, fail_cnt, dbg_state, core_clr);
                end
            end
        end
        n = 0;
        while (alarm === 1'b1 && n < LOCKOUT_CYCLES + 20) begin
            key_valid = (n < 6);
            key_bit   = 1'b1;
            enter     = (n == 3);
            relock    = (n == 4);
            n++;
            @(negedge clk);
        end
        key_valid = 1'b0;
        key_bit   = 1'b0;
        enter     = 1'b0;
        relock    = 1'b0;
        checks++;
        if (n != LOCKOUT_CYCLES) begin
            errors++;
            $display("FAIL lockout_len: alarm high %0d cycles, required %0d", n, LOCKOUT_CYCLES);
        end
        checks++;
        if (fail_cnt !== 2'd0 || core_clr !== 1'b1 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL lockout_exit: fc=%0d clr=%b state=%0d, required 0 1 0", fail_cnt, core_clr, dbg_state);
        end
    endtask

    task automatic test_overflow();
        core_unlocked = 1'b1;
        step_cnt = 0;
        for (int i = 0; i <= MAX_BITS; i++) begin
            send_bit(i[0] ^ i[2], i < MAX_BITS);
        end
        press_enter();
        wait_cycles(2);
        checks++;
        if (unlock !== 1'b0 || fail_cnt !== 2'd1 || core_clr !== 1'b1) begin
            errors++;
            $display("FAIL overflow_result: unlock=%b fc=%0d clr=%b, required 0 1 1", unlock, fail_cnt, core_clr);
        end
        checks++;
        if (step_cnt != MAX_BITS || exp_q.size() != 0) begin
            errors++;
            $display("FAIL overflow_steps: steps=%0d pending=%0d, required %0d 0", step_cnt, exp_q.size(), MAX_BITS);
        end
    endtask

    task automatic test_key_enter_idle();
        core_unlocked = 1'b1;
        step_cnt = 0;
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
        checks++;
        if (dbg_state !== ST_IDLE || core_clr !== 1'b0) begin
            errors++;
            $display("FAIL relock_idle: state=%0d clr=%b, required 0 0", dbg_state, core_clr);
        end
        key_valid = 1'b1;
        key_bit   = 1'b1;
        enter     = 1'b1;
        exp_q.push_back(1'b1);
        @(negedge clk);
        key_valid = 1'b0;
        key_bit   = 1'b0;
        enter     = 1'b0;
        checks++;
        if (dbg_state !== ST_SETTLE || core_step !== 1'b1) begin
            errors++;
            $display("FAIL key_enter_settle: state=%0d step=%b, required %0d 1", dbg_state, core_step, ST_SETTLE);
        end
        @(negedge clk);
        checks++;
        if (dbg_state !== ST_CHECK || core_step !== 1'b0) begin
            errors++;
            $display("FAIL key_enter_check: state=%0d step=%b, required %0d 0", dbg_state, core_step, ST_CHECK);
        end
        @(negedge clk);
        checks++;
        if (unlock !== 1'b1 || fail_cnt !== 2'd0 || step_cnt != 1) begin
            errors++;
            $display("FAIL key_enter_open: unlock=%b fc=%0d steps=%0d, required 1 0 1", unlock, fail_cnt, step_cnt);
        end
        wait_cycles(3);
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
        checks++;
        if (unlock !== 1'b0 || core_clr !== 1'b1 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL relock_drop: unlock=%b clr=%b state=%0d, required 0 1 0", unlock, core_clr, dbg_state);
        end
        @(negedge clk);
        checks++;
        if (core_clr !== 1'b0) begin
            errors++;
            $display("FAIL relock_clr_single: core_clr=%b, required 0", core_clr);
        end
    endtask

    task automatic test_timeout();
        int n;
        core_unlocked = 1'b1;
        send_bit(1'b0, 1'b1);
        n = 0;
        while (dbg_state === ST_ENTRY && n < ENTRY_TIMEOUT + 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != ENTRY_TIMEOUT || dbg_state !== ST_SETTLE) begin
            errors++;
            $display("FAIL timeout_len: entry idle %0d cycles state=%0d, required %0d %0d",
                     n, dbg_state, ENTRY_TIMEOUT, ST_SETTLE);
        end
        wait_cycles(2);
        checks++;
        if (core_clr !== 1'b1 || fail_cnt !== 2'd1 || unlock !== 1'b0) begin
            errors++;
            $display("FAIL timeout_result: clr=%b fc=%0d unlock=%b, required 1 1 0", core_clr, fail_cnt, unlock);
        end
    endtask

    task automatic test_reset_async();
        send_bit(1'b1, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (fail_cnt !== 2'd0 || dbg_state !== ST_IDLE || core_step !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_entry: fc=%0d state=%0d step=%b, required 0 0 0", fail_cnt, dbg_state, core_step);
        end
        @(negedge clk);
        reset = 1'b1;
        core_unlocked = 1'b1;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        press_enter();
        wait_cycles(2);
        checks++;
        if (unlock !== 1'b1) begin
            errors++;
            $display("FAIL reset_setup_open: unlock=%b, required 1", unlock);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (unlock !== 1'b0 || core_clr !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_in_open: unlock=%b clr=%b state=%0d, required 0 0 0", unlock, core_clr, dbg_state);
        end
        @(negedge clk);
        reset = 1'b1;
        wait_cycles(3);
        checks++;
        if (core_clr !== 1'b0 || unlock !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_after: clr=%b unlock=%b pending=%0d, required 0 0 0", core_clr, unlock, exp_q.size());
        end
    endtask

    // test sequence and final report
    initial begin
        test_reset();
        test_correct_code();
        test_wrong_code();
        test_overflow();
        test_key_enter_idle();
        test_timeout();
        test_reset_async();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_entry_controller.md
# lock_entry_controller

Sequencing controller for the serial-code lock core. Accepts keypad code bits with a submit strobe and gates them into the core one step at a time. It samples the core's unlocked flag after submission and drives the door-unlock output. It also enforces entry timeout, failed-attempt counting, timed lockout with alarm, and relock of the door.

## Interface
- MAX_BITS, 16: maximum code bits accepted per entry attempt
- ENTRY_TIMEOUT, 1000: idle cycles in ENTRY before the attempt is failed
- OPEN_CYCLES, 5000: cycles unlock stays high (auto-relock build only)
- MAX_FAILS, 3: consecutive failed attempts that trigger lockout
- LOCKOUT_CYCLES, 10000: lockout duration in cycles
- TW, 16: width of the shared cycle timer; all cycle parameters must be < 2^TW

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clock clk
- key_valid  in  1  one code bit presented this cycle
- key_bit  in  1  code bit value, qualified by key_valid
- enter  in  1  submit strobe, single-cycle pulse
- relock  in  1  manual relock request, honoured only in OPEN
- core_unlocked  in  1  core's unlocked flag
- core_x  out  1  registered code bit to core
- core_step  out  1  core advances on cycles where core_step=1
- core_clr  out  1  one-cycle synchronous clear of core to its initial state
- unlock  out  1  door actuator
- alarm  out  1  high throughout LOCKOUT
- fail_cnt  out  2  consecutive failed attempts, saturating at MAX_FAILS

## Operation
- States: IDLE, ENTRY, SETTLE, CHECK, OPEN, LOCKOUT.
- Reset values: state IDLE; all outputs 0; bit count, timer and force_fail flag cleared.
- IDLE:
  - key_valid forwards the bit and goes to ENTRY with bit count 1.
  - key_valid together with enter forwards the bit and goes to SETTLE.
  - enter alone is ignored.
- ENTRY:
  - Each key_valid forwards the bit, increments the bit count and reloads the timer.
  - key_valid when the bit count already equals MAX_BITS: the bit is dropped and force_fail is set.
  - enter goes to SETTLE. A key_valid in the same cycle is forwarded first.
  - The timer reaching ENTRY_TIMEOUT with no key sets force_fail and goes to SETTLE.
- SETTLE: one cycle. Lets the last forwarded bit propagate through the core.
- CHECK: one cycle. Pass when core_unlocked=1 and force_fail=0.
  - Pass: fail_cnt cleared, go to OPEN.
  - Fail: fail_cnt incremented; go to LOCKOUT if the new value equals MAX_FAILS, else IDLE.
- OPEN: unlock=1.
  - relock returns to IDLE.
  - With auto-relock compiled in, the timer reaching OPEN_CYCLES also returns to IDLE.
- LOCKOUT: alarm=1. After LOCKOUT_CYCLES, fail_cnt is cleared and the state goes to IDLE.
- Every transition into IDLE from another state pulses core_clr for exactly one cycle, and clears the bit count and force_fail.
- Inputs ignored:
  - key_valid and enter: in SETTLE, CHECK, OPEN and LOCKOUT.
  - relock: outside OPEN.
- Timer: a single TW-bit counter, cleared on every state change and counting up otherwise.

## Timing
- A bit accepted in cycle n appears as core_x/core_step=1 in cycle n+1. core_step is a single-cycle pulse per bit.
- enter accepted in cycle n:
  - SETTLE in n+1, CHECK in n+2 (samples core_unlocked).
  - unlock or core_clr visible in n+3; alarm in n+3 when lockout triggers.
- relock in cycle m while in OPEN: unlock=0 and core_clr=1 in m+1.
- Asynchronous reset mid-attempt, mid-OPEN or mid-LOCKOUT:
  - All outputs drop to 0 immediately and the state returns to IDLE.
  - fail_cnt is lost.
  - No core_clr pulse is issued, since the core shares the system reset.

## Configuration
- LOCK_AUTO_RELOCK_EN defined: OPEN exits on relock or when the timer reaches OPEN_CYCLES, whichever comes first.
- LOCK_AUTO_RELOCK_EN undefined: OPEN is held indefinitely until relock. The OPEN_CYCLES compare logic is not built.

## Test plan
- Correct code, then enter: unlock=1 exactly 3 cycles after enter, fail_cnt=0. Auto-relock build: unlock falls and core_clr pulses after OPEN_CYCLES.
- Wrong code 3 times: fail_cnt steps 1, 2, then alarm=1 three cycles after the third enter. alarm falls after LOCKOUT_CYCLES and fail_cnt returns to 0. key_valid during lockout produces no core_step.
- 17 bits, then enter (MAX_BITS=16): only 16 core_step pulses; CHECK fails even with core_unlocked=1; fail_cnt=1.
- One bit, then silence: after ENTRY_TIMEOUT cycles the attempt fails, fail_cnt=1, and core_clr pulses.
- key_valid together with enter in IDLE: exactly one core_step, then SETTLE and CHECK. relock in OPEN drops unlock next cycle. Reset asserted in OPEN clears unlock immediately.
